edge_pulse_gen: RTL and testbench
=================================

// Module: edge_pulse_gen
// PURPOSE
//   Multi-channel edge-to-pulse generator; generalises the single-channel rising-edge strobe.
//   Per channel: synchroniser -> glitch filter -> edge detect (rise/fall/both) -> pulse stretcher.
//   Sits between asynchronous trigger/enable inputs (scan start, laser fire, encoder index)
//   and the send/acquisition logic, which needs clean, fixed-length, clk-domain strobes.
// PARAMETERS
//   CH_NUM       4   number of independent channels (>=1)
//   SYNC_STAGES  2   synchroniser flops per channel (>=2)
//   FILT_CYCLES  4   consecutive stable cycles before filtered level changes (>=1)
//   PULSE_LEN    1   pulse_out high time in clk cycles (>=1)
//   CNT_W        derived, clog2(max(FILT_CYCLES,PULSE_LEN)+1); localparam, not overridable
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       async active-low reset
//   sig_in     in   CH_NUM  asynchronous input levels
//   edge_mode  in   2       00 none, 01 rising, 10 falling, 11 both; shared by all channels
//   enable     in   1       1 = pulses allowed; 0 = pulse_out forced low
//   level_out  out  CH_NUM  filtered, synchronised level per channel
//   pulse_out  out  CH_NUM  stretched edge strobe per channel
//   busy       out  1       OR of all pulse_out bits
// BEHAVIOUR
//   Reset: all sync flops, filter counters, level_out, pulse_out, busy = 0; stretch counters = 0.
//   Sync: sig_in[i] shifts through SYNC_STAGES flops; sync_q[i] = last stage.
//   Filter, per channel:
//   - sync_q == level_out: filter counter cleared.
//   - Differ: counter increments each clk. When it reaches FILT_CYCLES-1 while still differing,
//     level_out <= sync_q on that edge and counter clears.
//   - A mismatch shorter than FILT_CYCLES cycles leaves level_out unchanged (glitch rejected).
//   Edge qualification:
//   - Happens on the same edge as the level_out update.
//   - rise = 0->1, fall = 1->0; qualified per edge_mode sampled on that edge.
//   Latency: sig_in stable before clk edge k -> level_out and pulse_out high after edge
//     k+SYNC_STAGES+FILT_CYCLES-1 (6 edges, k..k+5, with defaults).
//   Stretcher:
//   - Qualified edge with enable=1: pulse_out <= 1, counter loaded with PULSE_LEN-1.
//   - Counter decrements while pulse_out=1; pulse_out <= 0 on the edge where counter==0.
//   - Result: exactly PULSE_LEN cycles high.
//   - Retrigger while high: counter reloads (pulse extended, no low gap, no double count).
//   enable=0:
//   - pulse_out and stretch counters cleared on next edge.
//   - Sync and filter keep tracking, so re-enable produces no spurious pulse.
//   - Edges during enable=0 are lost.
//   edge_mode change mid-pulse: active pulse completes; new mode applies to later edges.
//   edge_mode=00: level_out still updates, pulse_out stays 0.
//   Reset release with sig_in high: level_out rises after latency; rising pulse emitted if mode allows.
//   Reset mid-pulse: outputs drop to 0 immediately (async).
//   busy: combinational OR of the registered pulse_out bits.
//   Channels are fully independent; simultaneous edges on several channels pulse in the same cycle.
// STRUCTURE
//   edge_pulse_pkg:
//   - EDGE_NONE/EDGE_RISE/EDGE_FALL/EDGE_BOTH constants (2-bit).
//   - clog2 function used for CNT_W.
//   edge_pulse_ch:
//   - Sub-module with one channel's sync chain, filter, edge qualify and stretcher.
//   - Ports: clk, rst_n, sig_in, edge_mode, enable, level_out, pulse_out.
//   - Top generates CH_NUM instances and ORs pulse_out into busy.
// TESTING
//   1 Defaults, mode=01, ch0 0->1 held -> pulse_out[0] high 1 cycle, 6 edges after the change; other channels 0.
//   2 Glitch: ch1 high for 3 cycles then low (FILT_CYCLES=4) -> level_out[1], pulse_out[1] stay 0.
//   3 PULSE_LEN=5, mode=11, ch2 toggles with 20-cycle period -> 5-cycle pulse on every edge; busy matches.
//   4 PULSE_LEN=8, mode=11, FILT_CYCLES=1, ch3 edges 4 cycles apart -> one pulse, 12 cycles high, no gap.
//   5 enable=0, ch0 0->1, wait 10, enable=1 -> no pulse; level_out[0]=1; next 1->0 with mode=10 pulses.
//   6 rst_n low mid-pulse -> pulse_out, level_out, busy = 0 immediately; after release, sig_in high -> one rise pulse after latency.

Source files
------------

// File: rtl/edge_pulse_pkg.sv
// Shared edge-mode encodings and elaboration-time helpers for the edge pulse generator.
// No datapath; referenced only at elaboration and inside combinational qualify logic.
package edge_pulse_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Called only when the filtered level is about to flip, so new_lvl alone tells rise from fall.
  function automatic logic edge_qual(input logic [1:0] mode, input logic new_lvl);
    if (new_lvl) return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    else         return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_pulse_ch.sv
// One channel: synchroniser -> glitch filter -> edge qualify -> pulse stretcher.
// Latency SYNC_STAGES+FILT_CYCLES-1 edges from stable input to level/pulse; no backpressure, enable=0 drops edges.
module edge_pulse_ch
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int PULSE_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  logic [1:0] edge_mode,
  input  logic       enable,
  output logic       level_out,
  output logic       pulse_out
);

  localparam int CNT_W = clog2(max_int(FILT_CYCLES, PULSE_LEN) + 1);
  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0]       str_cnt_q, str_cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_lvl;
  logic                   edge_hit;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
    level_d    = level_q;
    filt_cnt_d = '0;
    edge_hit   = 1'b0;
    if (sync_lvl != level_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        level_d  = sync_lvl;
        edge_hit = edge_qual(edge_mode, sync_lvl);
      end else begin
        filt_cnt_d = filt_cnt_q + CNT_W'(1);
      end
    end

    pulse_d   = pulse_q;
    str_cnt_d = str_cnt_q;
    if (!enable) begin
      pulse_d   = 1'b0;
      str_cnt_d = '0;
    end else if (edge_hit) begin
      // A retrigger reloads the counter, so an active pulse is extended without a gap.
      pulse_d   = 1'b1;
      str_cnt_d = PULSE_LAST;
    end else if (pulse_q) begin
      if (str_cnt_q == '0) pulse_d = 1'b0;
      else                 str_cnt_d = str_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      filt_cnt_q <= '0;
      str_cnt_q  <= '0;
      level_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      filt_cnt_q <= filt_cnt_d;
      str_cnt_q  <= str_cnt_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: independent filtered, stretched strobes per async input.
// Latency SYNC_STAGES+FILT_CYCLES-1 edges; no backpressure, busy is the OR of registered pulses.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int PULSE_LEN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] sig_in,
  input  logic [1:0]        edge_mode,
  input  logic              enable,
  output logic [CH_NUM-1:0] level_out,
  output logic [CH_NUM-1:0] pulse_out,
  output logic              busy
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    edge_pulse_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .PULSE_LEN   (PULSE_LEN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in[i]),
      .edge_mode (edge_mode),
      .enable    (enable),
      .level_out (level_out[i]),
      .pulse_out (pulse_out[i])
    );
  end

  assign busy = |pulse_out;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: three instances cover default, long-pulse and fast-filter configs.
module tb_edge_pulse_gen;
  import edge_pulse_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] edge_mode;
  logic       enable;
  logic [3:0] sig_a, sig_b, sig_c;
  logic [3:0] lvl_a, lvl_b, lvl_c;
  logic [3:0] pls_a, pls_b, pls_c;
  logic       busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  edge_pulse_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_a), .edge_mode(edge_mode), .enable(enable),
    .level_out(lvl_a), .pulse_out(pls_a), .busy(busy_a)
  );

  edge_pulse_gen #(.PULSE_LEN(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_b), .edge_mode(edge_mode), .enable(enable),
    .level_out(lvl_b), .pulse_out(pls_b), .busy(busy_b)
  );

  edge_pulse_gen #(.FILT_CYCLES(1), .PULSE_LEN(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_c), .edge_mode(edge_mode), .enable(enable),
    .level_out(lvl_c), .pulse_out(pls_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] seen_p;
    logic [3:0] seen_l;
    logic [3:0] exp_v;
    int         high_cnt;
    int         rises;
    logic       prev;

    edge_mode = EDGE_RISE;
    enable    = 1'b1;
    sig_a     = '0;
    sig_b     = '0;
    sig_c     = '0;
    rst_n     = 1'b0;

    #2;
    chk("rst_lvl_a",  32'(lvl_a),  32'h0);
    chk("rst_pls_a",  32'(pls_a),  32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_pls_b",  32'(pls_b),  32'h0);
    chk("rst_pls_c",  32'(pls_c),  32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single rising edge on ch0: pulse appears after the sixth edge, lasts one cycle.
    sig_a[0] = 1'b1;
    tick(5);
    chk("t1_pre",   32'(pls_a),  32'h0);
    chk("t1_lvlpre",32'(lvl_a),  32'h0);
    tick(1);
    chk("t1_pulse", 32'(pls_a),  32'h1);
    chk("t1_level", 32'(lvl_a),  32'h1);
    chk("t1_busy",  32'(busy_a), 32'h1);
    tick(1);
    chk("t1_end",   32'(pls_a),  32'h0);
    chk("t1_hold",  32'(lvl_a),  32'h1);

    // Three-cycle glitch on ch1 is shorter than the filter window.
    seen_p = '0;
    seen_l = '0;
    sig_a[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) sig_a[1] = 1'b0;
      tick(1);
      seen_p |= pls_a;
      seen_l |= lvl_a;
    end
    chk("t2_pulse", 32'(seen_p[1]), 32'h0);
    chk("t2_level", 32'(seen_l[1]), 32'h0);

    // Mode none: level follows, no pulse.
    edge_mode = EDGE_NONE;
    seen_p = '0;
    sig_c[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen_p |= pls_c;
    end
    chk("tn_level", 32'(lvl_c[0]), 32'h1);
    chk("tn_pulse", 32'(seen_p),   32'h0);

    // Edge while disabled is lost; re-enable must not produce a pulse.
    edge_mode = EDGE_RISE;
    seen_p = '0;
    sig_a[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen_p |= pls_a;
    end
    enable   = 1'b0;
    sig_a[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 10) enable = 1'b1;
      tick(1);
      seen_p |= pls_a;
    end
    chk("t5_nopulse", 32'(seen_p),   32'h0);
    chk("t5_level",   32'(lvl_a[0]), 32'h1);
    edge_mode = EDGE_FALL;
    sig_a[0]  = 1'b0;
    tick(5);
    chk("t5_pre",   32'(pls_a), 32'h0);
    tick(1);
    chk("t5_fall",  32'(pls_a), 32'h1);
    chk("t5_lvl0",  32'(lvl_a), 32'h0);
    tick(1);
    chk("t5_end",   32'(pls_a), 32'h0);

    // Both edges, 5-cycle pulses, ch2 toggling every 10 cycles.
    edge_mode = EDGE_BOTH;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc % 10 == 0) sig_b[2] = ~sig_b[2];
      tick(1);
      exp_v = ((cyc % 10) >= 5) ? 4'b0100 : 4'b0000;
      chk("t3_pulse", 32'(pls_b),  32'(exp_v));
      chk("t3_busy",  32'(busy_b), 32'(|exp_v));
    end
    tick(2);

    // Retrigger on ch3 four cycles into an 8-cycle pulse: one 12-cycle pulse.
    high_cnt = 0;
    rises    = 0;
    prev     = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 0) sig_c[3] = 1'b1;
      if (cyc == 4) sig_c[3] = 1'b0;
      tick(1);
      exp_v = (cyc >= 2 && cyc <= 13) ? 4'b1000 : 4'b0000;
      chk("t4_pulse", 32'(pls_c), 32'(exp_v));
      if (pls_c[3]) high_cnt++;
      if (pls_c[3] && !prev) rises++;
      prev = pls_c[3];
    end
    chk("t4_len",   32'(high_cnt), 32'd12);
    chk("t4_rises", 32'(rises),    32'd1);

    // Async reset in the middle of a 5-cycle pulse, then re-acquire a held-high input.
    edge_mode = EDGE_RISE;
    sig_b[0]  = 1'b1;
    tick(7);
    chk("t6_mid",   32'(pls_b), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rpls",  32'(pls_b),  32'h0);
    chk("t6_rlvl",  32'(lvl_b),  32'h0);
    chk("t6_rbusy", 32'(busy_b), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(5);
    chk("t6_pre",   32'(pls_b), 32'h0);
    tick(1);
    chk("t6_pulse", 32'(pls_b), 32'h1);
    chk("t6_level", 32'(lvl_b), 32'h1);
    tick(4);
    chk("t6_held",  32'(pls_b), 32'h1);
    tick(1);
    chk("t6_end",   32'(pls_b), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
